// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_pkg
// Purpose  : Shared constants for the PC / instruction fetch unit: FSM state
//            encoding, instruction width, PC increment, alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package pc_fetch_unit_pkg;

  // Instruction / address width used across the fetch unit
  localparam int INST_W = 32;

  // Sequential fetch stride (one 32-bit word)
  localparam logic [INST_W-1:0] PC_INC = 32'd4;

  // Fetch FSM encoding
  localparam logic [1:0] ST_REQ  = 2'd0;  // issue request to instruction memory
  localparam logic [1:0] ST_WAIT = 2'd1;  // request accepted, awaiting response
  localparam logic [1:0] ST_HOLD = 2'd2;  // instruction presented to decode

  // Force an address onto a word boundary
  function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Purpose  : Bundles the redirect, instruction-memory and decode handshakes
//            of the fetch unit. master = fetch unit, slave = environment.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  // Redirect from the next-PC mux
  logic [INST_W-1:0] next_pc;
  logic              redirect;
  logic [INST_W-1:0] pc_plus4;
  logic [INST_W-1:0] pc;

  // Instruction memory request / response
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [INST_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;

  // Decode handshake
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_data;
  logic [INST_W-1:0] inst_pc;

  // Sticky alignment error
  logic              misalign_err;

  modport master (
    input  next_pc, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output pc_plus4, pc, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           misalign_err
  );

  modport slave (
    output next_pc, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  pc_plus4, pc, imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           misalign_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Purpose  : Program counter register with load enable; resets to the
//            configured reset vector.
// Revision : 1.0 - initial release
// ============================================================================
module pc_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_load,
  input  logic [INST_W-1:0] pc_d,
  output logic [INST_W-1:0] pc_q
);

  // Hold the PC; update only when the fetch FSM requests a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (pc_load) begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Single-outstanding instruction fetch unit. Issues one request at
//            the current PC, captures the response, presents it to decode and
//            then advances. A redirect overrides everything in its cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_unit_if.master        bus
);

  logic [1:0]        state_q, state_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_data_q, inst_data_d;
  logic [INST_W-1:0] inst_pc_q, inst_pc_d;
  logic              misalign_q, misalign_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic              pc_load;
  logic [INST_W-1:0] redirect_pc;

  assign redirect_pc = align_word(bus.next_pc);

  pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .pc_load (pc_load),
    .pc_d    (pc_d),
    .pc_q    (pc_q)
  );

  // Next-state logic: redirect first, then the normal request/wait/hold flow
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    inst_data_d = inst_data_q;
    inst_pc_d   = inst_pc_q;
    pc_d        = pc_q;
    pc_load     = 1'b0;
    misalign_d  = misalign_q | (bus.redirect && (bus.next_pc[1:0] != 2'b00));

    if (bus.redirect) begin
      pc_d    = redirect_pc;
      pc_load = 1'b1;
      case (state_q)
        ST_WAIT: begin
          // A response in this same cycle is simply discarded; otherwise
          // the still-pending response must be swallowed when it arrives.
          if (bus.imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          // REQ: request was masked this cycle, so nothing is in flight.
          // HOLD: the held instruction is squashed.
          state_d = ST_REQ;
          drop_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (bus.imem_req_ready) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              state_d = ST_REQ;
              drop_d  = 1'b0;
            end else begin
              inst_data_d = bus.imem_rsp_data;
              inst_pc_d   = pc_q;
              pc_d        = pc_q + PC_INC;
              pc_load     = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State, captured instruction and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_REQ;
      drop_q      <= 1'b0;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      inst_data_q <= inst_data_d;
      inst_pc_q   <= inst_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  // The request is masked during reset and in the redirect cycle so the
  // memory never accepts a fetch for a PC that is about to be replaced.
  assign bus.imem_req_valid = (state_q == ST_REQ) && !bus.redirect && !rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_q + PC_INC;
  assign bus.inst_valid     = (state_q == ST_HOLD);
  assign bus.inst_data      = inst_data_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.misalign_err   = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit: directed vector table,
//            reset / stall sequences and a randomized run against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdr;
    logic [31:0] npc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_id;
    logic        e_mis;
  } vec_t;

  vec_t tbl [30];

  // Instruction memory contents as a function of address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input logic rdr, input logic [31:0] npc, input logic rdy,
                              input logic rv, input logic [31:0] rd, input logic ir,
                              input logic erv, input logic [31:0] epc, input logic eiv,
                              input logic [31:0] eipc, input logic emis);
    vec_t v;
    v.rdr = rdr; v.npc = npc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
    v.e_rv = erv; v.e_pc = epc; v.e_iv = eiv; v.e_ipc = eipc; v.e_id = memf(eipc);
    v.e_mis = emis;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rdr, input logic [31:0] npc, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic ir);
    bus.redirect       = rdr;
    bus.next_pc        = npc;
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.inst_ready     = ir;
  endtask

  task automatic chk_reset(input int idx);
    chk("rst_req_valid", idx, 32'(bus.imem_req_valid), 32'd0);
    chk("rst_inst_valid", idx, 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", idx, bus.inst_data, 32'd0);
    chk("rst_inst_pc", idx, bus.inst_pc, 32'd0);
    chk("rst_misalign", idx, 32'(bus.misalign_err), 32'd0);
    chk("rst_pc", idx, bus.pc, 32'd0);
  endtask

  // Random-phase reference model state
  logic        pend;
  logic [31:0] pend_a;
  int          cnt;
  logic [31:0] exp_pc;
  logic        exp_mis;
  int          delivered;
  logic        r_rdr, r_rdy, r_rv, r_ir;
  logic [31:0] r_npc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    // ---------------- directed vector table ----------------
    //             rdr npc           rdy rv  rd                   ir   erv epc           eiv eipc          emis
    tbl[0]  = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h0,        0, 32'h0,        0);
    tbl[1]  = mk(0, 32'h0,        0, 1, memf(32'h0),         1,   0, 32'h0,        0, 32'h0,        0);
    tbl[2]  = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'h4,        1, 32'h0,        0);
    tbl[3]  = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h4,        0, 32'h0,        0);
    tbl[4]  = mk(0, 32'h0,        0, 1, memf(32'h4),         1,   0, 32'h4,        0, 32'h0,        0);
    tbl[5]  = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'h8,        1, 32'h4,        0);
    tbl[6]  = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h8,        0, 32'h0,        0);
    tbl[7]  = mk(0, 32'h0,        0, 1, memf(32'h8),         1,   0, 32'h8,        0, 32'h0,        0);
    tbl[8]  = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'hC,        1, 32'h8,        0);
    tbl[9]  = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'hC,        0, 32'h0,        0);
    tbl[10] = mk(1, 32'h100,      0, 0, 32'h0,               1,   0, 32'hC,        0, 32'h0,        0);
    tbl[11] = mk(0, 32'h0,        0, 1, memf(32'hC),         1,   0, 32'h100,      0, 32'h0,        0);
    tbl[12] = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h100,      0, 32'h0,        0);
    tbl[13] = mk(0, 32'h0,        0, 1, memf(32'h100),       1,   0, 32'h100,      0, 32'h0,        0);
    tbl[14] = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'h104,      1, 32'h100,      0);
    tbl[15] = mk(1, 32'h203,      0, 0, 32'h0,               1,   0, 32'h104,      0, 32'h0,        0);
    tbl[16] = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h200,      0, 32'h0,        1);
    tbl[17] = mk(0, 32'h0,        0, 1, memf(32'h200),       1,   0, 32'h200,      0, 32'h0,        1);
    tbl[18] = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'h204,      1, 32'h200,      1);
    tbl[19] = mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0,              1,   0, 32'h204,      0, 32'h0,        1);
    tbl[20] = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'hFFFF_FFFC, 0, 32'h0,       1);
    tbl[21] = mk(0, 32'h0,        0, 1, memf(32'hFFFF_FFFC), 1,   0, 32'hFFFF_FFFC, 0, 32'h0,       1);
    tbl[22] = mk(0, 32'h0,        0, 0, 32'h0,               1,   0, 32'h0,        1, 32'hFFFF_FFFC, 1);
    tbl[23] = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h0,        0, 32'h0,        1);
    tbl[24] = mk(1, 32'h40,       0, 1, memf(32'h0),         1,   0, 32'h0,        0, 32'h0,        1);
    tbl[25] = mk(0, 32'h0,        0, 0, 32'h0,               1,   1, 32'h40,       0, 32'h0,        1);
    tbl[26] = mk(0, 32'h0,        1, 0, 32'h0,               1,   1, 32'h40,       0, 32'h0,        1);
    tbl[27] = mk(0, 32'h0,        0, 1, memf(32'h40),        1,   0, 32'h40,       0, 32'h0,        1);
    tbl[28] = mk(1, 32'h80,       0, 0, 32'h0,               0,   0, 32'h44,       1, 32'h40,       1);
    tbl[29] = mk(0, 32'h0,        0, 0, 32'h0,               1,   1, 32'h80,       0, 32'h0,        1);

    // Reset values while rst is held high
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset(0);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      drive(tbl[i].rdr, tbl[i].npc, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ir);
      #1;
      chk("tbl_req_valid", i, 32'(bus.imem_req_valid), 32'(tbl[i].e_rv));
      chk("tbl_pc", i, bus.pc, tbl[i].e_pc);
      chk("tbl_req_addr", i, bus.imem_req_addr, tbl[i].e_pc);
      chk("tbl_pc_plus4", i, bus.pc_plus4, tbl[i].e_pc + 32'd4);
      chk("tbl_inst_valid", i, 32'(bus.inst_valid), 32'(tbl[i].e_iv));
      chk("tbl_misalign", i, 32'(bus.misalign_err), 32'(tbl[i].e_mis));
      if (tbl[i].e_iv) begin
        chk("tbl_inst_pc", i, bus.inst_pc, tbl[i].e_ipc);
        chk("tbl_inst_data", i, bus.inst_data, tbl[i].e_id);
      end
    end

    // ---------------- reset while a request is outstanding ----------------
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);      // pc 0x80 accepted -> WAIT
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset(1);
    @(negedge clk);
    #1;
    chk_reset(2);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, memf(32'h80), 1'b1);  // late response
    #1;
    chk("rst_release_req_valid", 0, 32'(bus.imem_req_valid), 32'd1);
    chk("rst_release_pc", 0, bus.pc, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("late_rsp_inst_valid", 0, 32'(bus.inst_valid), 32'd0);
    chk("late_rsp_req_valid", 0, 32'(bus.imem_req_valid), 32'd1);
    chk("late_rsp_pc", 0, bus.pc, 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, memf(32'h0), 1'b0);
    #1;

    // ---------------- decode stall for five cycles ----------------
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      chk("stall_inst_valid", k, 32'(bus.inst_valid), 32'd1);
      chk("stall_inst_pc", k, bus.inst_pc, 32'h0);
      chk("stall_inst_data", k, bus.inst_data, memf(32'h0));
      chk("stall_req_valid", k, 32'(bus.imem_req_valid), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("stall_release_valid", 0, 32'(bus.inst_valid), 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("after_stall_req_valid", 0, 32'(bus.imem_req_valid), 32'd1);
    chk("after_stall_req_addr", 0, bus.imem_req_addr, 32'h4);

    // ---------------- randomized run vs reference model ----------------
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0; pend_a = 32'h0; cnt = 0;
    exp_pc = 32'h0; exp_mis = 1'b0; delivered = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_rv  = pend && (cnt == 0);
      r_rdr = ($urandom_range(0, 15) == 0);
      r_npc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 1023));
      r_rdy = ($urandom_range(0, 3) != 0);
      r_ir  = ($urandom_range(0, 2) != 0);
      drive(r_rdr, r_npc, r_rdy, r_rv, memf(pend_a), r_ir);
      #1;
      chk("rnd_misalign", c, 32'(bus.misalign_err), 32'(exp_mis));
      if (bus.imem_req_valid) begin
        chk("rnd_req_addr", c, bus.imem_req_addr, exp_pc);
        chk("rnd_pc", c, bus.pc, exp_pc);
        chk("rnd_pc_plus4", c, bus.pc_plus4, exp_pc + 32'd4);
        chk("rnd_one_outstanding", c, 32'(pend), 32'd0);
      end
      if (bus.inst_valid) begin
        chk("rnd_inst_pc", c, bus.inst_pc, exp_pc);
        chk("rnd_inst_data", c, bus.inst_data, memf(exp_pc));
      end

      // Architectural effect of this cycle
      if (r_rdr && (r_npc[1:0] != 2'b00)) exp_mis = 1'b1;
      if (bus.inst_valid && r_ir && !r_rdr) begin
        delivered++;
        exp_pc = exp_pc + 32'd4;
      end
      if (r_rdr) exp_pc = {r_npc[31:2], 2'b00};

      // Memory model: single response after 1..3 cycles
      if (r_rv) pend = 1'b0;
      if (bus.imem_req_valid && r_rdy) begin
        pend   = 1'b1;
        pend_a = bus.imem_req_addr;
        cnt    = $urandom_range(0, 2);
      end else if (pend && cnt > 0) begin
        cnt--;
      end
    end
    chk("rnd_delivered_min", 0, 32'(delivered > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 next_pc  input  32  redirect target, driven by the 32-bit 2:1 next-PC bus mux.
REQ-005 redirect  input  1  1 = next_pc is valid (taken branch/jump); single-cycle pulse.
REQ-006 pc_plus4  output  32  pc + 4; feeds in0 of the next-PC mux.
REQ-007 pc  output  32  address of the current/outstanding fetch.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  32  fetch address, equal to pc.
REQ-011 imem_rsp_valid  input  1  instruction word returned (one per accepted request, latency >= 1 cycle).
REQ-012 imem_rsp_data  input  32  returned instruction word.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst_ready  input  1  decode accepts instruction.
REQ-015 inst_data  output  32  instruction word.
REQ-016 inst_pc  output  32  PC of inst_data.
REQ-017 misalign_err  output  1  sticky; set when redirect carries next_pc[1:0] != 2'b00.

Function
REQ-018 FSM states REQ, WAIT, HOLD; at most one request outstanding.
REQ-019 REQ: imem_req_valid = 1; on imem_req_ready go to WAIT.
REQ-020 WAIT: on imem_rsp_valid capture data into inst_data/inst_pc, pc <= pc + 4, go to HOLD.
REQ-021 HOLD: inst_valid = 1; on inst_ready the handshake completes and the block goes to REQ next cycle (no bypass; fetch throughput is one instruction per 3 cycles minimum).
REQ-022 inst_data/inst_pc stay stable while inst_valid = 1 and inst_ready = 0.
REQ-023 redirect in REQ: pc <= {next_pc[31:2], 2'b00}; stay in REQ, request drops for one cycle if not yet accepted.
REQ-024 redirect in WAIT: pc <= aligned next_pc; set drop flag; the pending response is discarded (no inst_valid), then go to REQ.
REQ-025 redirect and imem_rsp_valid in the same WAIT cycle: response discarded, go to REQ at aligned next_pc.
REQ-026 redirect in HOLD: inst_valid deasserts next cycle; held instruction is squashed; pc <= aligned next_pc; go to REQ.
REQ-027 redirect has priority over every other event in the same cycle.
REQ-028 pc_plus4 = pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-029 misalign_err clears only on reset; the fetch proceeds at the word-aligned address.

Reset
REQ-030 rst asserted: state = REQ, pc = RESET_VECTOR, drop flag = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, misalign_err = 0, imem_req_valid = 0 while rst high.
REQ-031 First request is issued the first cycle after rst deasserts.
REQ-032 Reset mid-transaction abandons the outstanding request; any response arriving in the first cycle after reset is ignored.

Structure
REQ-033 Shared package holds the FSM state encoding, the instruction width (32) and the 32'd4 PC increment.
REQ-034 One sub-module: pc_reg, a 32-bit register with async active-high reset to RESET_VECTOR and load enable.

Verification
REQ-035 Reset then free-run, 1-cycle memory, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8, and misalign_err = 0.
REQ-036 inst_ready = 0 for 5 cycles in HOLD -> inst_data/inst_pc stable, no new imem_req_valid.
REQ-037 redirect with next_pc = 0x100 while in WAIT -> response for the old pc is dropped; next inst_pc = 0x100.
REQ-038 redirect with next_pc = 0x203 -> misalign_err = 1 and held; fetch at 0x200.
REQ-039 pc = 0xFFFF_FFFC -> pc_plus4 = 0x0000_0000, next fetch at 0x0.
REQ-040 rst pulse while in WAIT -> all outputs at reset values; the late response is ignored; fetch restarts at RESET_VECTOR.
